// File: rtl/timer_seg_display.sv
// 2-digit multiplexed 7-seg driver for the countdown timer: dashes when idle, seconds while running,
// "00" flash with alarm after expiry. Optional buzzer output when TIMER_BEEP_EN is defined.
module timer_seg_display #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLINK_HZ    = 2,
  parameter int BLINK_COUNT = 3,
  parameter int BEEP_DIV    = 25_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_active,
  input  logic [3:0] time_left,
  input  logic       timer_done,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       alarm
`ifdef TIMER_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALVES    = 2 * BLINK_COUNT;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HALF_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BLNK_W    = (HALVES > 1) ? $clog2(HALVES) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, BLINK} state_t;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  endfunction

  logic              active_r, done_r;
  logic [3:0]        time_r;
  logic [SCAN_W-1:0] scan_cnt, nxt_scan;
  logic              sel, nxt_sel, scan_wrap;
  state_t            state, nxt_state;
  logic              phase_off, nxt_off;
  logic [HALF_W-1:0] half_cnt, nxt_half;
  logic [BLNK_W-1:0] blink_cnt, nxt_blink;
  logic [6:0]        nxt_seg;
  logic              tens;
  logic [3:0]        ones;

  // Next state and outputs are computed together so outputs land one cycle after the input register.
  always_comb begin
    scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    nxt_scan  = scan_wrap ? '0 : scan_cnt + 1'b1;
    nxt_sel   = sel ^ scan_wrap;
    nxt_state = state;
    nxt_off   = phase_off;
    nxt_half  = half_cnt;
    nxt_blink = blink_cnt;
    if (done_r) begin
      nxt_state = BLINK;
      nxt_off   = 1'b0;
      nxt_half  = '0;
      nxt_blink = '0;
    end else begin
      case (state)
        IDLE: if (active_r) nxt_state = SHOW;
        SHOW: if (!active_r) nxt_state = IDLE;
        BLINK: begin
          if (half_cnt == HALF_W'(BLINK_DIV - 1)) begin
            nxt_half = '0;
            if (blink_cnt == BLNK_W'(HALVES - 1)) begin
              nxt_state = active_r ? SHOW : IDLE;
              nxt_blink = '0;
              nxt_off   = 1'b0;
            end else begin
              nxt_blink = blink_cnt + 1'b1;
              nxt_off   = ~phase_off;
            end
          end else begin
            nxt_half = half_cnt + 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end

    tens = (time_r >= 4'd10);
    ones = tens ? time_r - 4'd10 : time_r;
    case (nxt_state)
      SHOW:    nxt_seg = nxt_sel ? (tens ? 7'h06 : 7'h00) : dec(ones);
      BLINK:   nxt_seg = nxt_off ? 7'h00 : 7'h3F;
      default: nxt_seg = 7'h40;
    endcase
  end

`ifdef TIMER_BEEP_EN
  localparam int BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  logic [BEEP_W-1:0] beep_cnt, nxt_beep_cnt;
  logic              nxt_beep, beep_restart;

  // Counter restarts on any fresh ON phase, including a flash restart mid-ON.
  always_comb begin
    beep_restart = done_r || (state != BLINK) || phase_off;
    nxt_beep_cnt = '0;
    nxt_beep     = 1'b0;
    if (nxt_state == BLINK && !nxt_off && !beep_restart) begin
      if (beep_cnt == BEEP_W'(BEEP_DIV - 1)) begin
        nxt_beep = ~beep;
      end else begin
        nxt_beep_cnt = beep_cnt + 1'b1;
        nxt_beep     = beep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt <= '0;
      beep     <= 1'b0;
    end else begin
      beep_cnt <= nxt_beep_cnt;
      beep     <= nxt_beep;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r  <= 1'b0;
      done_r    <= 1'b0;
      time_r    <= '0;
      scan_cnt  <= '0;
      sel       <= 1'b0;
      state     <= IDLE;
      phase_off <= 1'b0;
      half_cnt  <= '0;
      blink_cnt <= '0;
      seg       <= '0;
      an        <= 2'b00;
      alarm     <= 1'b0;
    end else begin
      active_r  <= timer_active;
      done_r    <= timer_done;
      time_r    <= time_left;
      scan_cnt  <= nxt_scan;
      sel       <= nxt_sel;
      state     <= nxt_state;
      phase_off <= nxt_off;
      half_cnt  <= nxt_half;
      blink_cnt <= nxt_blink;
      seg       <= nxt_seg;
      an        <= nxt_sel ? 2'b10 : 2'b01;
      alarm     <= (nxt_state == BLINK);
    end
  end

endmodule

// File: tb/tb_timer_seg_display.sv
// Directed bench for timer_seg_display using the small simulation parameter set.
module tb_timer_seg_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timer_active = 1'b0;
  logic [3:0] time_left = 4'd0;
  logic       timer_done = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       alarm;
`ifdef TIMER_BEEP_EN
  logic       beep;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  timer_seg_display #(
    .CLK_FREQ(1000), .SCAN_HZ(100), .BLINK_HZ(50), .BLINK_COUNT(3), .BEEP_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timer_active(timer_active), .time_left(time_left),
    .timer_done(timer_done), .seg(seg), .an(an), .alarm(alarm)
`ifdef TIMER_BEEP_EN
    , .beep(beep)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Wait (bounded) for a given digit enable, then compare the segments shown on it.
  task automatic wait_an(input logic [1:0] target, input string tag, input logic [6:0] exp_seg);
    int n = 0;
    while (an !== target && n < 25) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) check({tag, "_timeout"}, 32'(an), 32'(target));
    else check(tag, 32'(seg), 32'(exp_seg));
  endtask

  // Pulse timer_done now; optionally pulse again after edge restart_k. Checks every cycle.
  task automatic run_blink(input int restart_k, input int n, input logic expect_dash);
    int e, idx;
    logic ph_off;
    timer_done = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e = (restart_k > 0 && k >= restart_k + 2) ? restart_k + 2 : 2;
      idx = k - e;
      if (idx < 0) begin
        check($sformatf("blink_k%0d_alarm", k), 32'(alarm), 32'd0);
      end else if (idx < 60) begin
        ph_off = ((idx / 10) % 2) == 1;
        check($sformatf("blink_k%0d_alarm", k), 32'(alarm), 32'd1);
        check($sformatf("blink_k%0d_seg", k), 32'(seg), ph_off ? 32'h00 : 32'h3F);
`ifdef TIMER_BEEP_EN
        check($sformatf("blink_k%0d_beep", k), 32'(beep),
              ph_off ? 32'd0 : 32'(((idx % 10) / 2) % 2));
`endif
      end else begin
        check($sformatf("blink_k%0d_alarm", k), 32'(alarm), 32'd0);
        if (expect_dash) check($sformatf("blink_k%0d_seg", k), 32'(seg), 32'h40);
`ifdef TIMER_BEEP_EN
        check($sformatf("blink_k%0d_beep", k), 32'(beep), 32'd0);
`endif
      end
      if (k == 1) timer_done = 1'b0;
      if (restart_k > 0 && k == restart_k) timer_done = 1'b1;
      if (restart_k > 0 && k == restart_k + 1) timer_done = 1'b0;
    end
  endtask

  initial begin
    // 1: reset values, then digit alternation every 10 clocks
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_an", 32'(an), 32'h0);
    check("rst_alarm", 32'(alarm), 32'd0);
`ifdef TIMER_BEEP_EN
    check("rst_beep", 32'(beep), 32'd0);
`endif
    rst_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_k%0d", k), 32'(an), ((k / 10) % 2) == 1 ? 32'h2 : 32'h1);
    end
    check("idle_dash", 32'(seg), 32'h40);

    // 2: running with 12 s left
    timer_active = 1'b1;
    time_left = 4'd12;
    repeat (3) @(negedge clk);
    wait_an(2'b01, "t12_ones", 7'h5B);
    wait_an(2'b10, "t12_tens", 7'h06);

    // 3: single digit blanks tens; stopping returns to dashes within 2 clocks
    time_left = 4'd7;
    repeat (3) @(negedge clk);
    wait_an(2'b01, "t7_ones", 7'h07);
    wait_an(2'b10, "t7_tens", 7'h00);
    timer_active = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_dash", 32'(seg), 32'h40);
    wait_an(2'b01, "stop_dash_ones", 7'h40);
    wait_an(2'b10, "stop_dash_tens", 7'h40);

    // 4: expiry while still active -> flash, then back to SHOW
    timer_active = 1'b1;
    time_left = 4'd4;
    repeat (3) @(negedge clk);
    run_blink(0, 64, 1'b0);
    wait_an(2'b01, "post_blink_ones", 7'h66);
    wait_an(2'b10, "post_blink_tens", 7'h00);

    // 5: second expiry 25 clocks into the flash restarts it; exit to IDLE
    timer_active = 1'b0;
    repeat (3) @(negedge clk);
    run_blink(25, 92, 1'b1);

    // 6: asynchronous reset in the middle of an ON phase
    timer_done = 1'b1;
    @(negedge clk);
    timer_done = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_alarm", 32'(alarm), 32'd1);
`ifdef TIMER_BEEP_EN
    check("mid_beep", 32'(beep), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h00);
    check("arst_an", 32'(an), 32'h0);
    check("arst_alarm", 32'(alarm), 32'd0);
`ifdef TIMER_BEEP_EN
    check("arst_beep", 32'(beep), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_seg", 32'(seg), 32'h40);
    check("rel_alarm", 32'(alarm), 32'd0);
    check("rel_an", 32'(an), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
